// File: rtl/pattern_drive_buffer.sv
// Pattern drive buffer: NO_BUFS banks of driver/tweak fields, a pwm-synchronous
// buffer sweeper, and registered driver outputs with sense-gated tweak channels.
module pattern_drive_buffer #(
   parameter int WIDTH     = 8,
   parameter int NUM_TWEAK = 8,
   parameter int NO_BUFS   = 8,
   parameter int BUF_W     = 3,
   parameter int FIELD_W   = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       pwm,
   input  logic                       wr_en,
   input  logic [BUF_W-1:0]           wr_buf,
   input  logic [FIELD_W-1:0]         wr_field,
   input  logic [WIDTH-1:0]           wr_data,
   input  logic [BUF_W-1:0]           rd_buf,
   input  logic [FIELD_W-1:0]         rd_field,
   output logic [WIDTH-1:0]           rd_data,
   input  logic                       fixed_mode,
   input  logic [BUF_W-1:0]           fixed_buf,
   output logic [BUF_W-1:0]           buffer_select,
   output logic                       sweep_done,
   output logic [WIDTH-1:0]           p_drive,
   output logic [WIDTH-1:0]           n_drive,
   output logic [WIDTH-1:0]           tweak_delay,
   output logic [NUM_TWEAK*WIDTH-1:0] tweak_drive
);

   localparam int NUM_FIELDS = 4 + NUM_TWEAK;
   localparam int F_PDRIVE   = 0;
   localparam int F_NDRIVE   = 1;
   localparam int F_SENSE    = 2;
   localparam int F_DELAY    = 3;
   localparam int F_TWEAK0   = 4;

   // One extra bit so the bound stays representable when 2^FIELD_W == NUM_FIELDS.
   localparam logic [FIELD_W:0]   NUM_FIELDS_W = (FIELD_W+1)'(NUM_FIELDS);
   localparam logic [BUF_W-1:0]   LAST_BUF     = BUF_W'(NO_BUFS - 1);

   logic [WIDTH-1:0]     mem [NO_BUFS][NUM_FIELDS];

   logic                 wr_ok;
   logic                 rd_ok;
   logic                 pwm_prev;
   logic                 fixed_prev;
   logic                 pwm_edge;
   logic                 mode_drop;
   logic                 sense_valid;
   logic [NUM_TWEAK-1:0] sense_prev;
   logic [NUM_TWEAK-1:0] cur_sense;

   logic [BUF_W-1:0]     bs_nxt;
   logic                 sv_nxt;
   logic [NUM_TWEAK-1:0] sp_nxt;

   assign wr_ok = wr_en && ({1'b0, wr_field} < NUM_FIELDS_W);
   assign rd_ok = ({1'b0, rd_field} < NUM_FIELDS_W);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int b = 0; b < NO_BUFS; b++) begin
            for (int f = 0; f < NUM_FIELDS; f++) begin
               mem[b][f] <= '0;
            end
         end
      end else if (wr_ok) begin
         mem[wr_buf][wr_field] <= wr_data;
      end
   end

   // Read-back samples the array before this edge's write lands, so a
   // same-cycle read/write of one location returns the old word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_data <= '0;
      end else if (rd_ok) begin
         rd_data <= mem[rd_buf][rd_field];
      end else begin
         rd_data <= '0;
      end
   end

   assign pwm_edge  = (pwm != pwm_prev);
   assign mode_drop = fixed_prev && !fixed_mode;
   assign cur_sense = mem[buffer_select][F_SENSE][NUM_TWEAK-1:0];

   always_comb begin
      bs_nxt = buffer_select;
      sv_nxt = sense_valid;
      sp_nxt = sense_prev;
      if (fixed_mode) begin
         bs_nxt = fixed_buf;
         if (pwm_edge) begin
            sv_nxt = 1'b0;
         end else begin
            sv_nxt = 1'b1;
            sp_nxt = cur_sense;
         end
      end else if (pwm_edge || mode_drop) begin
         bs_nxt = '0;
         sv_nxt = 1'b0;
      end else begin
         bs_nxt = (buffer_select == LAST_BUF) ? buffer_select : buffer_select + 1'b1;
         sv_nxt = 1'b1;
         sp_nxt = cur_sense;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pwm_prev      <= 1'b0;
         fixed_prev    <= 1'b0;
         buffer_select <= '0;
         sense_valid   <= 1'b0;
         sense_prev    <= '0;
      end else begin
         pwm_prev      <= pwm;
         fixed_prev    <= fixed_mode;
         buffer_select <= bs_nxt;
         sense_valid   <= sv_nxt;
         sense_prev    <= sp_nxt;
      end
   end

   assign sweep_done = !fixed_mode && (buffer_select == LAST_BUF);

   // A tweak channel drives only while its sensed polarity matches pwm.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         p_drive     <= '0;
         n_drive     <= '0;
         tweak_delay <= '0;
         tweak_drive <= '0;
      end else begin
         p_drive     <= mem[buffer_select][F_PDRIVE];
         n_drive     <= mem[buffer_select][F_NDRIVE];
         tweak_delay <= mem[buffer_select][F_DELAY];
         for (int i = 0; i < NUM_TWEAK; i++) begin
            if (sense_valid && (sense_prev[i] == pwm)) begin
               tweak_drive[i*WIDTH +: WIDTH] <= mem[buffer_select][F_TWEAK0 + i];
            end else begin
               tweak_drive[i*WIDTH +: WIDTH] <= '0;
            end
         end
      end
   end

endmodule

// File: tb/tb_pattern_drive_buffer.sv
// Directed bench for pattern_drive_buffer; inputs change and outputs are
// sampled 1 time unit after each rising clk edge.
module tb_pattern_drive_buffer;

   localparam int WIDTH     = 8;
   localparam int NUM_TWEAK = 8;
   localparam int NO_BUFS   = 8;
   localparam int BUF_W     = 3;
   localparam int FIELD_W   = 4;

   logic                       clk = 1'b0;
   logic                       rst;
   logic                       pwm;
   logic                       wr_en;
   logic [BUF_W-1:0]           wr_buf;
   logic [FIELD_W-1:0]         wr_field;
   logic [WIDTH-1:0]           wr_data;
   logic [BUF_W-1:0]           rd_buf;
   logic [FIELD_W-1:0]         rd_field;
   logic [WIDTH-1:0]           rd_data;
   logic                       fixed_mode;
   logic [BUF_W-1:0]           fixed_buf;
   logic [BUF_W-1:0]           buffer_select;
   logic                       sweep_done;
   logic [WIDTH-1:0]           p_drive;
   logic [WIDTH-1:0]           n_drive;
   logic [WIDTH-1:0]           tweak_delay;
   logic [NUM_TWEAK*WIDTH-1:0] tweak_drive;

   int errors = 0;
   int checks = 0;

   pattern_drive_buffer #(
      .WIDTH(WIDTH), .NUM_TWEAK(NUM_TWEAK), .NO_BUFS(NO_BUFS),
      .BUF_W(BUF_W), .FIELD_W(FIELD_W)
   ) dut (
      .clk(clk), .rst(rst), .pwm(pwm),
      .wr_en(wr_en), .wr_buf(wr_buf), .wr_field(wr_field), .wr_data(wr_data),
      .rd_buf(rd_buf), .rd_field(rd_field), .rd_data(rd_data),
      .fixed_mode(fixed_mode), .fixed_buf(fixed_buf),
      .buffer_select(buffer_select), .sweep_done(sweep_done),
      .p_drive(p_drive), .n_drive(n_drive), .tweak_delay(tweak_delay),
      .tweak_drive(tweak_drive)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic wr(input int b, input int f, input int d);
      wr_en    = 1'b1;
      wr_buf   = BUF_W'(b);
      wr_field = FIELD_W'(f);
      wr_data  = WIDTH'(d);
      step();
      wr_en    = 1'b0;
   endtask

   initial begin
      int m;
      rst = 1'b1; pwm = 1'b0; wr_en = 1'b0; wr_buf = '0; wr_field = '0;
      wr_data = '0; rd_buf = '0; rd_field = '0; fixed_mode = 1'b0; fixed_buf = '0;

      // Reset state
      repeat (2) step();
      chk("rst_sel", buffer_select, 0);
      chk("rst_done", sweep_done, 0);
      chk("rst_pdrv", p_drive, 0);
      chk("rst_tweak", tweak_drive, 0);
      chk("rst_rd", rd_data, 0);
      rst = 1'b0;
      step();

      // Storage write / read-back
      wr(3, 0, 8'hA5);
      rd_buf = 3'd3; rd_field = 4'd0;
      step();
      chk("rd_a5", rd_data, 8'hA5);
      wr(3, 0, 8'h3C);
      chk("rd_old_on_write", rd_data, 8'hA5);
      step();
      chk("rd_new", rd_data, 8'h3C);
      wr(3, 13, 8'h77);
      rd_field = 4'd13;
      step();
      chk("rd_field13", rd_data, 0);
      rd_field = 4'd5;
      step();
      chk("rd_no_alias", rd_data, 0);

      // Pattern load: every buffer senses 0x01 (ch0 follows pwm=1, ch1 pwm=0)
      for (int b = 0; b < NO_BUFS; b++) begin
         wr(b, 0, 8'h10 + b);
         wr(b, 1, 8'h20 + b);
         wr(b, 2, 8'h01);
         wr(b, 3, 8'h30 + b);
         wr(b, 4, (b == 0) ? 8'hFF : 8'hE0 + b);
         wr(b, 5, 8'h40 + b);
      end

      // Sweep after a falling pwm edge, pwm held 0
      pwm = 1'b1;
      repeat (3) step();
      pwm = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         m = (i < 7) ? i : 7;
         chk("sweep_sel", buffer_select, m);
         chk("sweep_done", sweep_done, (m == 7) ? 1 : 0);
         if (i >= 1) begin
            m = (i - 1 < 7) ? i - 1 : 7;
            chk("sweep_pdrv", p_drive, 8'h10 + m);
            chk("sweep_ndrv", n_drive, 8'h20 + m);
            chk("sweep_tdly", tweak_delay, 8'h30 + m);
         end
         if (i == 1) chk("sweep_gate", tweak_drive, 0);
         if (i >= 2) chk("sweep_tweak", tweak_drive, (64'h40 + m) << 8);
      end

      // Tweak gating on buffer 0 held in fixed mode
      fixed_mode = 1'b1; fixed_buf = 3'd0; pwm = 1'b1;
      step();
      chk("fix0_sel", buffer_select, 0);
      step();
      chk("fix0_gate", tweak_drive, 0);
      step();
      chk("fix0_ch0_on", tweak_drive, 64'h00FF);
      chk("fix0_pdrv", p_drive, 8'h10);
      pwm = 1'b0;
      step();
      chk("fix0_ch1_on", tweak_drive, 64'h4000);
      step();
      chk("fix0_edge_gate", tweak_drive, 0);
      step();
      chk("fix0_ch1_again", tweak_drive, 64'h4000);

      // Fixed buffer 6 through pwm edges, then back to sweep
      fixed_buf = 3'd6;
      step();
      chk("fix6_sel", buffer_select, 6);
      pwm = 1'b1;
      step();
      chk("fix6_sel_edge", buffer_select, 6);
      chk("fix6_done", sweep_done, 0);
      pwm = 1'b0;
      step();
      chk("fix6_sel_edge2", buffer_select, 6);
      step();
      chk("fix6_pdrv", p_drive, 8'h16);
      fixed_mode = 1'b0;
      step();
      chk("drop_sel0", buffer_select, 0);
      step();
      chk("drop_sel1", buffer_select, 1);
      chk("drop_gate", tweak_drive, 0);
      repeat (4) step();
      chk("sweep_sel5", buffer_select, 5);

      // pwm toggle at select 5
      pwm = 1'b1;
      step();
      chk("tog_sel0", buffer_select, 0);
      step();
      chk("tog_gate", tweak_drive, 0);
      chk("tog_sel1", buffer_select, 1);

      // pwm edge coinciding with a drop out of fixed mode
      fixed_mode = 1'b1; fixed_buf = 3'd2;
      step();
      chk("both_fix_sel", buffer_select, 2);
      fixed_mode = 1'b0; pwm = 1'b0;
      step();
      chk("both_sel0", buffer_select, 0);
      step();
      chk("both_sel1", buffer_select, 1);
      chk("both_gate", tweak_drive, 0);
      repeat (3) step();
      chk("pre_rst_sel4", buffer_select, 4);

      // Asynchronous reset mid-sweep
      rd_buf = 3'd0; rd_field = 4'd0;
      step();
      chk("pre_rst_rd", rd_data, 8'h10);
      #2 rst = 1'b1;
      #1;
      chk("arst_sel", buffer_select, 0);
      chk("arst_pdrv", p_drive, 0);
      chk("arst_ndrv", n_drive, 0);
      chk("arst_tdly", tweak_delay, 0);
      chk("arst_tweak", tweak_drive, 0);
      chk("arst_rd", rd_data, 0);
      step();
      rst = 1'b0;
      chk("rel_sel0", buffer_select, 0);
      step();
      chk("rel_sel1", buffer_select, 1);
      chk("rel_gate", tweak_drive, 0);
      chk("rel_mem_cleared", rd_data, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
